score_controller: RTL

- Game-level sequencer for the score counter chain: NDIG cascaded 4-bit counter digits, one decade per digit.
- Turns game frame ticks into score increments and makes each digit behave as a decade (0-9) counter.
- Generates the per-digit enable and synchronous-clear controls the chain needs, plus the game-start clear.
- Tracks game state and keeps the high score.
- Sits between the game FSM (frame_tick/start/collide) and the counter chain; feeds the display mux.

---
 rtl/score_controller.sv | 133 +++++++++++++
 1 files changed

// File: rtl/score_controller.sv
// Game-level sequencer for a cascaded BCD score counter chain: decade carry/clear
// controls, frame-tick scoring divider, game state tracking and high-score register.
module score_controller #(
    parameter int NDIG     = 4,
    parameter int TICK_DIV = 6
) (
    input  logic              CP,
    input  logic              C_R,
    input  logic              frame_tick,
    input  logic              start,
    input  logic              collide,
    input  logic [4*NDIG-1:0] score_q,
    output logic [NDIG-1:0]   dig_ct,
    output logic [NDIG-1:0]   dig_cr_n,
    output logic              cnt_clear,
    output logic [4*NDIG-1:0] hi_score,
    output logic              new_hi,
    output logic              sat,
    output logic [1:0]        state
);

    localparam int DIVW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SETTLE = 2'd2,
        DEAD   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DIVW-1:0]     div_q, div_d;
    logic                cnt_en_q, cnt_en_d;
    logic                clear_q, clear_d;
    logic [4*NDIG-1:0]   hi_q, hi_d;
    logic                new_hi_q, new_hi_d;
    logic                sat_q, sat_d;
    logic [NDIG-1:0]     nine;
    logic                allNine;
    logic                carry;

    always_comb begin
        for (int k = 0; k < NDIG; k++) begin
            nine[k] = (score_q[4*k +: 4] == 4'd9);
        end
    end

    assign allNine = &nine;

    // Ripple the increment strobe through every digit that currently reads 9;
    // a digit enabled while at 9 is cleared instead of counting to 10.
    always_comb begin
        carry    = cnt_en_q;
        dig_ct   = '0;
        dig_cr_n = '1;
        for (int k = 0; k < NDIG; k++) begin
            dig_ct[k]   = carry;
            dig_cr_n[k] = ~(carry & nine[k]);
            carry       = carry & nine[k];
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        cnt_en_d = 1'b0;
        clear_d  = 1'b0;
        hi_d     = hi_q;
        new_hi_d = new_hi_q;
        sat_d    = sat_q;
        unique case (state_q)
            IDLE, DEAD: begin
                if (start) begin
                    clear_d  = 1'b1;
                    div_d    = '0;
                    new_hi_d = 1'b0;
                    sat_d    = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (collide) begin
                    state_d = SETTLE;
                end else if (frame_tick) begin
                    if (div_q == DIV_LAST) begin
                        div_d = '0;
                        if (allNine) sat_d = 1'b1;
                        else         cnt_en_d = 1'b1;
                    end else begin
                        div_d = div_q + DIVW'(1);
                    end
                end
            end
            SETTLE: begin
                // Any in-flight increment has landed by now, so score_q is final.
                state_d = DEAD;
                if (score_q > hi_q) begin
                    hi_d     = score_q;
                    new_hi_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CP or negedge C_R) begin
        if (!C_R) begin
            state_q  <= IDLE;
            div_q    <= '0;
            cnt_en_q <= 1'b0;
            clear_q  <= 1'b0;
            hi_q     <= '0;
            new_hi_q <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            cnt_en_q <= cnt_en_d;
            clear_q  <= clear_d;
            hi_q     <= hi_d;
            new_hi_q <= new_hi_d;
            sat_q    <= sat_d;
        end
    end

    assign cnt_clear = clear_q;
    assign hi_score  = hi_q;
    assign new_hi    = new_hi_q;
    assign sat       = sat_q;
    assign state     = state_q;

endmodule
